// File: rtl/baser_257b_tx_scheduler.sv
// Gathers four 66b blocks into one 257b transcoded word with valid/ready handshakes on both sides.
// Define BASER_257B_AM_EN to insert a one-cycle alignment-marker gap every AM_PERIOD transferred words.
module baser_257b_tx_scheduler #(
    parameter int DATA_WIDTH = 64,
    parameter int TC_WIDTH   = 4*DATA_WIDTH+1,
    parameter int CNT_WIDTH  = 32,
    parameter int AM_PERIOD  = 1024
) (
    input  logic                  clk,
    input  logic                  i_rst_n,
    input  logic [DATA_WIDTH+1:0] i_blk,
    input  logic                  i_valid,
    output logic                  o_ready,
    output logic [TC_WIDTH-1:0]   o_tx_coded,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic                  o_am_slot,
    output logic [CNT_WIDTH-1:0]  o_block_count,
    output logic [CNT_WIDTH-1:0]  o_data_count,
    output logic [CNT_WIDTH-1:0]  o_ctrl_count,
    output logic [CNT_WIDTH-1:0]  o_hdr_err_count
);

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_EMIT    = 2'd1,
        ST_AM      = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [1:0]             idx_q, idx_d;
    logic [DATA_WIDTH-1:0]  slot_q [3];
    logic [DATA_WIDTH-1:0]  slot_d [3];
    logic [2:0]             flag_q, flag_d;
    logic                   rst_done_q;
    logic                   valid_q, valid_d;
    logic [TC_WIDTH-1:0]    word_q, word_d;
    logic [CNT_WIDTH-1:0]   block_cnt_q, block_cnt_d;
    logic [CNT_WIDTH-1:0]   data_cnt_q, data_cnt_d;
    logic [CNT_WIDTH-1:0]   ctrl_cnt_q, ctrl_cnt_d;
    logic [CNT_WIDTH-1:0]   err_cnt_q, err_cnt_d;

    logic                   in_am;
    logic                   cur_flag;
    logic                   hdr_err;
    logic                   accept;
    logic                   xfer;
    logic [DATA_WIDTH-1:0]  pay [4];
    logic [3:0]             flags;
    logic [TC_WIDTH-1:0]    built;
    int                     pos;
    logic                   squeezed;

`ifdef BASER_257B_AM_EN
    localparam int AmW = (AM_PERIOD > 1) ? $clog2(AM_PERIOD) : 1;
    logic [AmW-1:0]         am_cnt_q, am_cnt_d;
    assign in_am = (state_q == ST_AM);
`else
    assign in_am = 1'b0;
`endif

    assign cur_flag  = (i_blk[1:0] == 2'b01);
    assign hdr_err   = (i_blk[1:0] == 2'b00) || (i_blk[1:0] == 2'b11);
    assign o_ready   = rst_done_q && !in_am && (!valid_q || i_ready);
    assign o_valid   = valid_q && !in_am;
    assign accept    = i_valid && o_ready;
    assign xfer      = o_valid && i_ready;

    assign o_am_slot       = in_am;
    assign o_tx_coded      = word_q;
    assign o_block_count   = block_cnt_q;
    assign o_data_count    = data_cnt_q;
    assign o_ctrl_count    = ctrl_cnt_q;
    assign o_hdr_err_count = err_cnt_q;

    // Word assembly: only the first ctrl block loses its type high nibble, so later payloads shift down by 4.
    always_comb begin
        pay[0]   = slot_q[0];
        pay[1]   = slot_q[1];
        pay[2]   = slot_q[2];
        pay[3]   = i_blk[DATA_WIDTH+1:2];
        flags    = {cur_flag, flag_q};
        built    = '0;
        pos      = 5;
        squeezed = 1'b0;
        if (&flags) begin
            built = {pay[3], pay[2], pay[1], pay[0], 1'b1};
        end else begin
            built[4:1] = flags;
            for (int k = 0; k < 4; k++) begin
                if (!flags[k] && !squeezed) begin
                    built    = built | (TC_WIDTH'({pay[k][DATA_WIDTH-1:8], pay[k][3:0]}) << pos);
                    pos      = pos + DATA_WIDTH - 4;
                    squeezed = 1'b1;
                end else begin
                    built = built | (TC_WIDTH'(pay[k]) << pos);
                    pos   = pos + DATA_WIDTH;
                end
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        slot_d      = slot_q;
        flag_d      = flag_q;
        valid_d     = valid_q;
        word_d      = word_q;
        block_cnt_d = block_cnt_q;
        data_cnt_d  = data_cnt_q;
        ctrl_cnt_d  = ctrl_cnt_q;
        err_cnt_d   = err_cnt_q;
`ifdef BASER_257B_AM_EN
        am_cnt_d    = am_cnt_q;
`endif

        if (xfer) begin
            valid_d     = 1'b0;
            block_cnt_d = block_cnt_q + CNT_WIDTH'(1);
            if (word_q[0]) begin
                data_cnt_d = data_cnt_q + CNT_WIDTH'(1);
            end else begin
                ctrl_cnt_d = ctrl_cnt_q + CNT_WIDTH'(1);
            end
        end

        if (accept && hdr_err) begin
            err_cnt_d = err_cnt_q + CNT_WIDTH'(1);
        end

        case (state_q)
            ST_COLLECT: begin
                if (accept) begin
                    slot_d[idx_q] = i_blk[DATA_WIDTH+1:2];
                    flag_d[idx_q] = cur_flag;
                    idx_d         = idx_q + 2'd1;
                end
            end
            ST_EMIT: begin
                if (accept) begin
                    word_d  = built;
                    valid_d = 1'b1;
                    idx_d   = 2'd0;
                end
            end
            default: begin
            end
        endcase

        state_d = (idx_d == 2'd3) ? ST_EMIT : ST_COLLECT;

`ifdef BASER_257B_AM_EN
        // The gap follows the transfer itself, so a word is never withdrawn once it has been presented.
        if (xfer) begin
            if (am_cnt_q == AmW'(AM_PERIOD - 1)) begin
                am_cnt_d = '0;
                state_d  = ST_AM;
            end else begin
                am_cnt_d = am_cnt_q + AmW'(1);
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_COLLECT;
            idx_q       <= 2'd0;
            slot_q      <= '{default: '0};
            flag_q      <= 3'd0;
            rst_done_q  <= 1'b0;
            valid_q     <= 1'b0;
            word_q      <= '0;
            block_cnt_q <= '0;
            data_cnt_q  <= '0;
            ctrl_cnt_q  <= '0;
            err_cnt_q   <= '0;
`ifdef BASER_257B_AM_EN
            am_cnt_q    <= '0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            slot_q      <= slot_d;
            flag_q      <= flag_d;
            rst_done_q  <= 1'b1;
            valid_q     <= valid_d;
            word_q      <= word_d;
            block_cnt_q <= block_cnt_d;
            data_cnt_q  <= data_cnt_d;
            ctrl_cnt_q  <= ctrl_cnt_d;
            err_cnt_q   <= err_cnt_d;
`ifdef BASER_257B_AM_EN
            am_cnt_q    <= am_cnt_d;
`endif
        end
    end

endmodule
